// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: merges ID/EX stall requests,
// sequences multi-cycle EX operations and applies MEM exception flushes.
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

module pipe_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             flush_req,
    input  logic [`RegBus]   flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [`RegBus]   new_pc,
    output logic             ex_mc_done,
    output logic             ex_mc_busy
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic {
        IDLE,
        MC_RUN
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] mc_len;

    // Lengths 0 and 1 behave as 2 so every op has at least one stall cycle.
    assign mc_len = (ex_mc_cycles < CNT_W'(2)) ? CNT_W'(2) : ex_mc_cycles;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = `ZeroWord;
        ex_mc_done = 1'b0;

        if (rst) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (flush_req) begin
            flush      = 1'b1;
            new_pc     = flush_pc;
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ex_mc_start) begin
                        stall      = STALL_EX;
                        cnt_next   = mc_len - CNT_W'(1);
                        state_next = MC_RUN;
                    end else if (stallreq_id) begin
                        stall = STALL_ID;
                    end
                end
                MC_RUN: begin
                    if (cnt > CNT_W'(1)) begin
                        stall    = STALL_EX;
                        cnt_next = cnt - CNT_W'(1);
                    end else begin
                        // Done cycle: a start request here belongs to the
                        // completing instruction and is deliberately dropped.
                        ex_mc_done = 1'b1;
                        stall      = stallreq_id ? STALL_ID : STALL_NONE;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ex_mc_busy <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ex_mc_busy <= (state_next == MC_RUN);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against an operation-level reference model
// that tracks each multi-cycle op by its position within the op.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_cycles;
    logic             flush_req;
    logic [31:0]      flush_pc;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             ex_mc_done;
    logic             ex_mc_busy;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .ex_mc_start (ex_mc_start),
        .ex_mc_cycles(ex_mc_cycles),
        .flush_req   (flush_req),
        .flush_pc    (flush_pc),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .ex_mc_done  (ex_mc_done),
        .ex_mc_busy  (ex_mc_busy)
    );

    int total = 0;
    int bad   = 0;

    // Model: an op of length n occupies cycles 1..n; pos is the current one.
    bit m_in_op = 1'b0;
    int m_len   = 0;
    int m_pos   = 0;
    bit first   = 1'b1;
    int cyc_no  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_no, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic id, input logic st,
                        input logic [CNT_W-1:0] cyc, input logic fl,
                        input logic [31:0] pc);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_done;
        logic        e_busy;
        int          n;

        @(negedge clk);
        rst = r; stallreq_id = id; ex_mc_start = st;
        ex_mc_cycles = cyc; flush_req = fl; flush_pc = pc;
        #1;

        e_stall = 6'b000000;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        e_done  = 1'b0;
        e_busy  = m_in_op;

        if (r) begin
            m_in_op = 1'b0;
        end else if (fl) begin
            e_flush = 1'b1;
            e_pc    = pc;
            m_in_op = 1'b0;
        end else if (!m_in_op) begin
            if (st) begin
                n       = (int'(cyc) < 2) ? 2 : int'(cyc);
                m_len   = n;
                m_pos   = 2;
                m_in_op = 1'b1;
                e_stall = 6'b001111;
            end else if (id) begin
                e_stall = 6'b000111;
            end
        end else begin
            if (m_pos == m_len) begin
                e_done  = 1'b1;
                e_stall = id ? 6'b000111 : 6'b000000;
                m_in_op = 1'b0;
            end else begin
                e_stall = 6'b001111;
                m_pos++;
            end
        end

        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("new_pc", new_pc, e_pc);
        chk("done", 32'(ex_mc_done), 32'(e_done));
        if (!first) chk("busy", 32'(ex_mc_busy), 32'(e_busy));
        first = 1'b0;
        cyc_no++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, '0, 0, 32'h0);
    endtask

    initial begin
        logic [CNT_W-1:0] c;
        rst = 1'b1; stallreq_id = 1'b0; ex_mc_start = 1'b0;
        ex_mc_cycles = '0; flush_req = 1'b0; flush_pc = 32'h0;

        // Reset with every input high
        step(1, 1, 1, '1, 1, 32'hFFFFFFFF);
        step(1, 1, 1, '1, 1, 32'hFFFFFFFF);
        idle(2);

        // Load-use
        step(0, 1, 0, '0, 0, 32'h0);
        idle(2);

        // Divide, N=34
        step(0, 0, 1, 6'd34, 0, 32'h0);
        idle(36);

        // Clamp with lengths 0 and 1
        step(0, 0, 1, 6'd0, 0, 32'h0);
        idle(3);
        step(0, 0, 1, 6'd1, 0, 32'h0);
        idle(3);

        // Abort five cycles into a 34-cycle op
        step(0, 0, 1, 6'd34, 0, 32'h0);
        idle(4);
        step(0, 0, 0, '0, 1, 32'h00000040);
        idle(40);

        // Flush in the start cycle
        step(0, 0, 1, 6'd10, 1, 32'h00001234);
        idle(3);

        // Overlap with ID stall, including the done cycle
        step(0, 0, 1, 6'd5, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, '0, 0, 32'h0);
        idle(2);

        // Start during done cycle is ignored; back-to-back next cycle
        step(0, 0, 1, 6'd3, 0, 32'h0);
        step(0, 0, 1, 6'd3, 0, 32'h0);
        step(0, 0, 1, 6'd3, 0, 32'h0);
        step(0, 0, 1, 6'd2, 0, 32'h0);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(20, 63))
                                            : CNT_W'($urandom_range(0, 8));
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 c,
                 ($urandom_range(0, 39) == 0),
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. Collects stall requests from ID (load-use hazard) and EX (multi-cycle mult/div), sequences multi-cycle EX operations with an internal counter, and drives the per-stage stall vector that gates every inter-stage pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also applies exception flushes from MEM and supplies the redirect PC to the fetch stage.

## Interface
Parameters:
- CNT_W, 6, width of the multi-cycle length input and internal counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_id  in  1  ID hazard; hold PC, IF/ID, ID/EX this cycle.
- ex_mc_start  in  1  EX holds a multi-cycle op; honoured only in IDLE.
- ex_mc_cycles  in  CNT_W  total op length N in cycles, start cycle included; values 0 and 1 are treated as 2.
- flush_req  in  1  exception raised in MEM.
- flush_pc  in  `RegBus  handler address.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  `RegBus  redirect target; valid when flush=1, else `ZeroWord.
- ex_mc_done  out  1  EX result is valid this cycle; EX/MEM captures it at this edge.
- ex_mc_busy  out  1  multi-cycle op in progress (state MC_RUN).

## Operation
- States: IDLE, MC_RUN. Counter cnt, CNT_W bits.
- Output priority each cycle: flush_req > EX multi-cycle stall > stallreq_id > none.
- flush_req=1, any state: flush=1, new_pc=flush_pc, stall=6'b000000, ex_mc_done=0. Next state is IDLE and cnt is cleared, aborting any running op.
- IDLE with ex_mc_start=1 (no flush):
  - stall=6'b001111.
  - cnt <= N-1, where N is the clamped length.
  - Next state MC_RUN.
- MC_RUN, cnt>1: stall=6'b001111; cnt <= cnt-1.
- MC_RUN, cnt==1 (done cycle):
  - ex_mc_done=1.
  - EX stall is released. stall=6'b000111 if stallreq_id, else 6'b000000.
  - Next state IDLE.
  - ex_mc_start is ignored this cycle because it belongs to the completing instruction.
- ex_mc_start while in MC_RUN is ignored.
- stallreq_id in IDLE with no other request: stall=6'b000111, which leaves a bubble in ID/EX. It has no effect on state.
- Stall encoding: a request from stage k holds stages 0..k. Bits 4 and 5 are never set by this block.
- While rst=1: all outputs take their reset values and state is forced to IDLE, cnt=0.

## Timing
- Reset values: stall=0, flush=0, new_pc=`ZeroWord, ex_mc_done=0, ex_mc_busy=0, state IDLE, cnt=0.
- stall, flush, new_pc and ex_mc_done are combinational from the current state, cnt and the current inputs, with zero latency.
- ex_mc_busy is a pure state decode, registered.
- Multi-cycle op of length N: stall[3:0]=1111 for exactly N-1 cycles, starting in the start cycle. ex_mc_done is high for exactly 1 cycle, the Nth. ex_mc_busy is high for cycles 2..N.
- A back-to-back op can start the cycle after done.
- Flush in the start cycle: the op is not started and the next state is IDLE.

## Test plan
- Reset: hold rst 2 cycles with every input high -> all outputs 0; after release with inputs low -> stall=000000, busy=0.
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=000111 that cycle, then 000000; ex_mc_busy stays 0.
- Divide, N=34: ex_mc_start at cycle t -> stall=001111 for cycles t..t+32, ex_mc_done=1 only at t+33 with stall=000000, busy high t+1..t+33.
- Clamp: ex_mc_cycles=0 -> stall=001111 for exactly 1 cycle, done in the next cycle.
- Abort: flush_req=1, flush_pc=32'h00000040, 5 cycles into a 34-cycle op -> flush=1, new_pc=32'h00000040, stall=000000 that cycle; next cycle IDLE, busy=0, no ex_mc_done ever asserted.
- Overlap: stallreq_id=1 during MC_RUN -> stall stays 001111; stallreq_id=1 in the done cycle -> stall=000111 with ex_mc_done=1.
